// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;
    localparam int unsigned CNT_W   = 8;

    // Phase encoding; the numeric values are visible on the phase output.
    typedef enum logic [STATE_W-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        FLASH       = 3'd6
    } state_e;

    // Lamp words are {red, yellow, green}.
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// Loadable down-counter advanced by the 1 Hz tick; holds at zero.
module phase_timer #(
    parameter int unsigned CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over counting; a zero count is held until reloaded.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road intersection phase sequencer with pedestrian walk and night flash.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MAIN_MIN = 10,
    parameter int unsigned GREEN_SIDE     = 8,
    parameter int unsigned YELLOW         = 3,
    parameter int unsigned ALL_RED        = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               side_sensor,
    input  logic               ped_button,
    input  logic               night_flash,
    output logic [LAMP_W-1:0]  main_lights,
    output logic [LAMP_W-1:0]  side_lights,
    output logic               walk,
    output logic [STATE_W-1:0] phase,
    output logic [CNT_W-1:0]   sec_remaining
);

    localparam logic [CNT_W-1:0] LD_GREEN_MAIN = CNT_W'(GREEN_MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_SIDE = CNT_W'(GREEN_SIDE - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(ALL_RED - 1);

    state_e            state_q, state_d;
    logic              side_req_q, side_req_d;
    logic              flash_on_q, flash_on_d;
    logic [LAMP_W-1:0] main_q, main_d;
    logic [LAMP_W-1:0] side_q, side_d;
    logic              walk_q, walk_d;

    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              done_c;
    logic [CNT_W-1:0]  cnt;

    // Value loaded into the timer on entry to a phase; FLASH keeps it at zero.
    function automatic logic [CNT_W-1:0] entry_load(input state_e s);
        case (s)
            MAIN_GREEN:  return LD_GREEN_MAIN;
            MAIN_YELLOW: return LD_YELLOW;
            SIDE_GREEN:  return LD_GREEN_SIDE;
            SIDE_YELLOW: return LD_YELLOW;
            ALL_RED_A:   return LD_ALL_RED;
            ALL_RED_B:   return LD_ALL_RED;
            default:     return '0;
        endcase
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_ALL_RED)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_i     (tick),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .done_c     (done_c)
    );

    // Next phase, timer load, flash toggle, request latch and next lamp word.
    always_comb begin
        state_d    = state_q;
        flash_on_d = flash_on_q;
        load       = 1'b0;
        load_val   = '0;
        main_d     = LAMP_RED;
        side_d     = LAMP_RED;
        walk_d     = 1'b0;

        if (tick) begin
            case (state_q)
                MAIN_GREEN:  if (done_c && (side_req_q || night_flash)) state_d = MAIN_YELLOW;
                MAIN_YELLOW: if (done_c) state_d = ALL_RED_A;
                ALL_RED_A:   if (done_c) state_d = night_flash ? FLASH : SIDE_GREEN;
                SIDE_GREEN:  if (done_c) state_d = SIDE_YELLOW;
                SIDE_YELLOW: if (done_c) state_d = ALL_RED_B;
                ALL_RED_B:   if (done_c) state_d = night_flash ? FLASH : MAIN_GREEN;
                FLASH: begin
                    if (!night_flash) begin
                        state_d = ALL_RED_B;
                    end else begin
                        flash_on_d = ~flash_on_q;
                    end
                end
                default:     state_d = ALL_RED_B;
            endcase
        end

        if (state_d != state_q) begin
            load     = 1'b1;
            load_val = entry_load(state_d);
            if (state_d == FLASH) begin
                flash_on_d = 1'b1;
            end
        end

        // The request being served is dropped as side green starts.
        if ((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN)) begin
            side_req_d = 1'b0;
        end else begin
            side_req_d = side_req_q | side_sensor | ped_button;
        end

        case (state_d)
            MAIN_GREEN:  main_d = LAMP_GRN;
            MAIN_YELLOW: main_d = LAMP_YEL;
            SIDE_GREEN: begin
                side_d = LAMP_GRN;
                walk_d = 1'b1;
            end
            SIDE_YELLOW: side_d = LAMP_YEL;
            FLASH: begin
                main_d = flash_on_d ? LAMP_YEL : LAMP_OFF;
                side_d = flash_on_d ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

    // State, request latch and registered lamp outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ALL_RED_B;
            side_req_q <= 1'b0;
            flash_on_q <= 1'b1;
            main_q     <= LAMP_RED;
            side_q     <= LAMP_RED;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            side_req_q <= side_req_d;
            flash_on_q <= flash_on_d;
            main_q     <= main_d;
            side_q     <= side_d;
            walk_q     <= walk_d;
        end
    end

    assign main_lights   = main_q;
    assign side_lights   = side_q;
    assign walk          = walk_q;
    assign phase         = state_q;
    assign sec_remaining = cnt;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm with a phase-level reference model.
module tb_traffic_light_fsm;

    logic       clock;
    logic       reset_n;
    logic       tick;
    logic       side_sensor;
    logic       ped_button;
    logic       night_flash;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic [2:0] phase;
    logic [7:0] sec_remaining;

    int errors = 0;
    int checks = 0;

    traffic_light_fsm #(
        .GREEN_MAIN_MIN (3),
        .GREEN_SIDE     (2),
        .YELLOW         (2),
        .ALL_RED        (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tick          (tick),
        .side_sensor   (side_sensor),
        .ped_button    (ped_button),
        .night_flash   (night_flash),
        .main_lights   (main_lights),
        .side_lights   (side_lights),
        .walk          (walk),
        .phase         (phase),
        .sec_remaining (sec_remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [17:0] dut_out;
    assign dut_out = {main_lights, side_lights, walk, phase, sec_remaining};

    // Reference model: phase index, ticks spent in phase, latched request, flash lamp.
    int         dur [6]      = '{3, 2, 1, 2, 2, 1};
    logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int         m_phase;
    int         m_elapsed;
    bit         m_req;
    bit         m_flash_on;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 5;
        m_elapsed  = 0;
        m_req      = 1'b0;
        m_flash_on = 1'b1;
    endtask

    function automatic int next_phase(input int p, input bit req, input bit nf);
        case (p)
            0:       return (req || nf) ? 1 : 0;
            1:       return 2;
            2:       return nf ? 6 : 3;
            3:       return 4;
            4:       return 5;
            default: return nf ? 6 : 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input bit t, input bit sensor, input bit ped, input bit nf);
        bit served = 1'b0;
        int nxt;
        if (t) begin
            if (m_phase == 6) begin
                if (!nf) begin
                    m_phase   = 5;
                    m_elapsed = 0;
                end else begin
                    m_flash_on = !m_flash_on;
                end
            end else if (m_elapsed >= dur[m_phase] - 1) begin
                nxt = next_phase(m_phase, m_req, nf);
                if (nxt != m_phase) begin
                    m_phase   = nxt;
                    m_elapsed = 0;
                    if (nxt == 6) m_flash_on = 1'b1;
                    if (nxt == 3) served = 1'b1;
                end
            end else begin
                m_elapsed++;
            end
        end
        m_req = served ? 1'b0 : (m_req | sensor | ped);
    endtask

    function automatic logic [17:0] model_out();
        logic [2:0] m, s;
        logic       w;
        logic [7:0] sec;
        if (m_phase == 6) begin
            m   = m_flash_on ? 3'b010 : 3'b000;
            s   = m_flash_on ? 3'b100 : 3'b000;
            w   = 1'b0;
            sec = 8'd0;
        end else begin
            m   = main_tab[m_phase];
            s   = side_tab[m_phase];
            w   = (m_phase == 3);
            sec = 8'(dur[m_phase] - 1 - m_elapsed);
        end
        return {m, s, w, 3'(m_phase), sec};
    endfunction

    // One clock with the given tick value, compared against the model afterwards.
    task automatic step(input logic t);
        tick = t;
        model_edge(t, side_sensor, ped_button, night_flash);
        @(posedge clock);
        #1;
        check("model", 32'(dut_out), 32'(model_out()));
    endtask

    task automatic run_tick(input int n);
        repeat (n) begin
            repeat (9) step(1'b0);
            step(1'b1);
        end
        tick = 1'b0;
    endtask

    task automatic pulse_ped();
        ped_button = 1'b1;
        step(1'b0);
        ped_button = 1'b0;
    endtask

    task automatic tick_until(input int ph, input int max_ticks, input string name);
        int n = 0;
        while ((int'(phase) != ph) && (n < max_ticks)) begin
            run_tick(1);
            n++;
        end
        check(name, 32'(phase), 32'(ph));
    endtask

    // Asynchronous reset assertion off the clock edge, then release.
    task automatic apply_reset();
        side_sensor = 1'b0;
        ped_button  = 1'b0;
        night_flash = 1'b0;
        tick        = 1'b0;
        #2 reset_n  = 1'b0;
        #1;
        check("async_reset", 32'(dut_out), 32'({3'b100, 3'b100, 1'b0, 3'd5, 8'd0}));
        @(negedge clock);
        #2 reset_n = 1'b1;
        model_reset();
    endtask

    // Safety: never yellow/green on both roads at once.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            checks++;
            if (((main_lights & 3'b011) != 3'b000) && ((side_lights & 3'b011) != 3'b000)) begin
                errors++;
                $display("FAIL safety: main=%b side=%b, one road must be red", main_lights, side_lights);
            end
        end
    end

    typedef struct {
        int         n_ticks;
        bit         ped;
        logic [2:0] ph;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       w;
        logic [7:0] sec;
    } vec_t;

    function automatic vec_t mk(input int n, input bit p, input logic [2:0] ph,
                                input logic [2:0] ml, input logic [2:0] sl,
                                input logic w, input logic [7:0] sec);
        vec_t v;
        v.n_ticks = n; v.ped = p; v.ph = ph; v.ml = ml; v.sl = sl; v.w = w; v.sec = sec;
        return v;
    endfunction

    vec_t tbl [13];
    vec_t fl  [8];

    initial begin
        // Pedestrian request served once, then main green holds with no request.
        tbl[0]  = mk(1, 0, 3'd0, 3'b001, 3'b100, 0, 8'd2);
        tbl[1]  = mk(1, 1, 3'd0, 3'b001, 3'b100, 0, 8'd1);
        tbl[2]  = mk(1, 0, 3'd0, 3'b001, 3'b100, 0, 8'd0);
        tbl[3]  = mk(1, 0, 3'd1, 3'b010, 3'b100, 0, 8'd1);
        tbl[4]  = mk(1, 0, 3'd1, 3'b010, 3'b100, 0, 8'd0);
        tbl[5]  = mk(1, 0, 3'd2, 3'b100, 3'b100, 0, 8'd0);
        tbl[6]  = mk(1, 0, 3'd3, 3'b100, 3'b001, 1, 8'd1);
        tbl[7]  = mk(1, 0, 3'd3, 3'b100, 3'b001, 1, 8'd0);
        tbl[8]  = mk(1, 0, 3'd4, 3'b100, 3'b010, 0, 8'd1);
        tbl[9]  = mk(1, 0, 3'd4, 3'b100, 3'b010, 0, 8'd0);
        tbl[10] = mk(1, 0, 3'd5, 3'b100, 3'b100, 0, 8'd0);
        tbl[11] = mk(1, 0, 3'd0, 3'b001, 3'b100, 0, 8'd2);
        tbl[12] = mk(6, 0, 3'd0, 3'b001, 3'b100, 0, 8'd0);
        // Night flash raised in side green (first tick), dropped before the 7th.
        fl[0] = mk(1, 0, 3'd3, 3'b100, 3'b001, 1, 8'd0);
        fl[1] = mk(1, 0, 3'd4, 3'b100, 3'b010, 0, 8'd1);
        fl[2] = mk(2, 0, 3'd5, 3'b100, 3'b100, 0, 8'd0);
        fl[3] = mk(1, 0, 3'd6, 3'b010, 3'b100, 0, 8'd0);
        fl[4] = mk(1, 0, 3'd6, 3'b000, 3'b000, 0, 8'd0);
        fl[5] = mk(1, 0, 3'd6, 3'b010, 3'b100, 0, 8'd0);
        fl[6] = mk(1, 0, 3'd5, 3'b100, 3'b100, 0, 8'd0);
        fl[7] = mk(1, 0, 3'd0, 3'b001, 3'b100, 0, 8'd2);

        reset_n     = 1'b0;
        tick        = 1'b0;
        side_sensor = 1'b0;
        ped_button  = 1'b0;
        night_flash = 1'b0;
        #23 reset_n = 1'b1;
        model_reset();
        check("reset_state", 32'(dut_out), 32'({3'b100, 3'b100, 1'b0, 3'd5, 8'd0}));

        // No requests: main green after one tick, then held for 20 ticks.
        run_tick(1);
        check("idle_first", 32'({phase, main_lights}), 32'({3'd0, 3'b001}));
        for (int k = 2; k <= 21; k++) begin
            run_tick(1);
            check("idle_phase", 32'(phase), 32'd0);
            if (k >= 3) check("idle_sec", 32'(sec_remaining), 32'd0);
        end

        // Directed table.
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].ped) pulse_ped();
            run_tick(tbl[i].n_ticks);
            check($sformatf("vec%0d", i), 32'(dut_out),
                  32'({tbl[i].ml, tbl[i].sl, tbl[i].w, tbl[i].ph, tbl[i].sec}));
        end

        // Side sensor held: main green runs of exactly 3 ticks every 11 ticks.
        apply_reset();
        side_sensor = 1'b1;
        begin
            int prev = 5, run_len = 0, runs = 0, last_start = -1;
            for (int k = 1; k <= 40; k++) begin
                run_tick(1);
                if (phase == 3'd0) begin
                    if (prev != 0) begin
                        if (last_start >= 0) check("sensor_period", 32'(k - last_start), 32'd11);
                        last_start = k;
                        run_len    = 0;
                    end
                    run_len++;
                end else if (prev == 0) begin
                    check("mg_len", 32'(run_len), 32'd3);
                    runs++;
                end
                prev = int'(phase);
            end
            check("mg_runs", 32'(runs >= 3), 32'd1);
        end
        side_sensor = 1'b0;

        // Button pressed on the very edge that enters side green.
        apply_reset();
        pulse_ped();
        tick_until(2, 12, "reach_all_red_a");
        repeat (9) step(1'b0);
        ped_button = 1'b1;
        step(1'b1);
        ped_button = 1'b0;
        tick = 1'b0;
        check("edge_ped_sg", 32'({phase, walk}), 32'({3'd3, 1'b1}));
        tick_until(0, 10, "edge_ped_back_mg");
        for (int k = 0; k < 6; k++) begin
            run_tick(1);
            check("edge_ped_hold", 32'(phase), 32'd0);
        end

        // Night flash entered from side green, then released.
        apply_reset();
        pulse_ped();
        tick_until(3, 12, "reach_side_green");
        night_flash = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) night_flash = 1'b0;
            run_tick(fl[i].n_ticks);
            check($sformatf("flash%0d", i), 32'(dut_out),
                  32'({fl[i].ml, fl[i].sl, fl[i].w, fl[i].ph, fl[i].sec}));
        end

        // Reset mid main yellow discards the pending request.
        apply_reset();
        side_sensor = 1'b1;
        tick_until(1, 12, "reach_main_yellow");
        side_sensor = 1'b0;
        repeat (3) step(1'b0);
        apply_reset();
        run_tick(1);
        for (int k = 0; k < 5; k++) begin
            run_tick(1);
            check("post_reset_hold", 32'(phase), 32'd0);
        end

        // Randomized traffic against the model.
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39) == 0) side_sensor = ~side_sensor;
            ped_button = ($urandom_range(49) == 0);
            if ($urandom_range(299) == 0) night_flash = ~night_flash;
            step((c % 10) == 9);
        end
        tick = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
